ddr2_cmd_scheduler: RTL and testbench

DDR2_CMD_SCHEDULER -- requirements
Module: ddr2_cmd_scheduler

---
 rtl/ddr2_cmd_scheduler.sv | 242 ++++++++++++++++++++++++
 tb/tb_ddr2_cmd_scheduler.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr2_cmd_scheduler.sv
`default_nettype none
// ===========================================================================
// ddr2_cmd_scheduler -- one-burst-at-a-time DDR2 command sequencer with refresh. Rev 1.0
// ===========================================================================
module ddr2_cmd_scheduler #(
  parameter int T_RCD  = 6,
  parameter int T_RP   = 6,
  parameter int T_WR   = 8,
  parameter int T_RFC  = 64,
  parameter int T_REFI = 3900,
  parameter int RL     = 8,
  parameter int WL     = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ready,
  input  logic        cmd_empty,
  input  logic [27:0] cmd_data,
  output logic        cmd_get,
  input  logic [6:0]  in_fillcount,
  output logic        wdata_get,
  input  logic [6:0]  ret_fillcount,
  output logic        ret_put,
  output logic [24:0] ret_addr,
  output logic        csbar,
  output logic        rasbar,
  output logic        casbar,
  output logic        webar,
  output logic [1:0]  ba,
  output logic [12:0] a,
  output logic        ts,
  output logic        ri,
  output logic        busy
);

  localparam int TMAX = WL + 7 + T_WR + RL + T_RCD + T_RP + T_RFC + 8;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int RW   = $clog2(T_REFI);

  localparam logic [TW-1:0] C_CMD_LAST = TW'(1);
  localparam logic [TW-1:0] C_RCD_LAST = TW'(T_RCD - 1);
  localparam logic [TW-1:0] C_RP_LAST  = TW'(T_RP - 1);
  localparam logic [TW-1:0] C_RFC_LAST = TW'(T_RFC - 1);
  localparam logic [TW-1:0] C_WDG_ON   = TW'(WL - 2);
  localparam logic [TW-1:0] C_WDG_OFF  = TW'(WL + 6);
  localparam logic [TW-1:0] C_TS_ON    = TW'(WL - 1);
  localparam logic [TW-1:0] C_TS_OFF   = TW'(WL + 7);
  localparam logic [TW-1:0] C_WREC_END = TW'(WL + 7 + T_WR - 1);
  localparam logic [TW-1:0] C_RI_ON    = TW'(RL - 1);
  localparam logic [TW-1:0] C_RI_OFF   = TW'(RL + 7);
  localparam logic [RW-1:0] C_REFI_LAST = RW'(T_REFI - 1);

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;

  typedef enum logic [3:0] {
    IDLE, ACT, RCD, RD, WR, BURST, WREC, PRE, RP, REF, RFC
  } state_t;

  state_t          r_state;
  logic [TW-1:0]   r_t;
  logic [RW-1:0]   r_refi_cnt;
  logic            r_ref_pending;
  logic [3:0]      r_pins;
  logic [1:0]      r_ba;
  logic [12:0]     r_a;
  logic [9:0]      r_col;
  logic            r_is_write;
  logic            r_cmd_get, r_wdata_get, r_ret_put, r_ts, r_ri, r_busy;
  logic [24:0]     r_ret_addr;

  logic [2:0]      w_cmd;
  logic [24:0]     w_addr;
  logic            w_eligible;
  logic            w_expire;
  logic            w_in_burst;

  assign w_cmd      = cmd_data[27:25];
  assign w_addr     = cmd_data[24:0];
  assign w_expire   = ready && (r_refi_cnt == C_REFI_LAST);
  assign w_in_burst = (r_state == RD) || (r_state == WR) || (r_state == BURST) || (r_state == WREC);

  always_comb begin
    w_eligible = 1'b1;
    if (w_cmd == 3'b001)      w_eligible = (ret_fillcount <= 7'd56);
    else if (w_cmd == 3'b010) w_eligible = (in_fillcount >= 7'd8);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_refi_cnt    <= '0;
      r_ref_pending <= 1'b0;
    end else begin
      if (!ready || w_expire) r_refi_cnt <= '0;
      else                    r_refi_cnt <= r_refi_cnt + 1'b1;
      if (w_expire)
        r_ref_pending <= 1'b1;
      else if (r_state == RP && r_t == C_RP_LAST && r_ref_pending)
        r_ref_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_t         <= '0;
      r_pins      <= C_NOP;
      r_ba        <= '0;
      r_a         <= '0;
      r_col       <= '0;
      r_is_write  <= 1'b0;
      r_cmd_get   <= 1'b0;
      r_wdata_get <= 1'b0;
      r_ret_put   <= 1'b0;
      r_ts        <= 1'b0;
      r_ri        <= 1'b0;
      r_busy      <= 1'b0;
      r_ret_addr  <= '0;
    end else begin
      r_cmd_get <= 1'b0;
      r_t       <= r_t + 1'b1;
      // Data strobes are timed from RD/WR start; r_t keeps running through BURST and WREC.
      if (w_in_burst) begin
        if (r_is_write) begin
          if (r_t == C_WDG_ON)       r_wdata_get <= 1'b1;
          else if (r_t == C_WDG_OFF) r_wdata_get <= 1'b0;
          if (r_t == C_TS_ON)        r_ts <= 1'b1;
          else if (r_t == C_TS_OFF)  r_ts <= 1'b0;
        end else begin
          if (r_t == C_RI_ON) begin
            r_ri      <= 1'b1;
            r_ret_put <= 1'b1;
          end else if (r_t == C_RI_OFF) begin
            r_ri      <= 1'b0;
            r_ret_put <= 1'b0;
          end
        end
      end
      case (r_state)
        IDLE: begin
          r_t <= '0;
          if (ready && r_ref_pending) begin
            r_state <= PRE;
            r_pins  <= C_PRE;
            r_a     <= 13'h0400;
            r_busy  <= 1'b1;
          end else if (ready && !cmd_empty && !r_cmd_get && w_eligible) begin
            // r_cmd_get blocks a second accept while the FIFO head is still being popped.
            r_cmd_get <= 1'b1;
            if (w_cmd == 3'b001 || w_cmd == 3'b010) begin
              r_is_write <= (w_cmd == 3'b010);
              r_col      <= w_addr[9:0];
              r_state    <= ACT;
              r_pins     <= C_ACT;
              r_ba       <= w_addr[11:10];
              r_a        <= w_addr[24:12];
              r_busy     <= 1'b1;
              if (w_cmd == 3'b001) r_ret_addr <= w_addr;
            end
          end
        end
        ACT: if (r_t == C_CMD_LAST) begin
          r_state <= RCD;
          r_pins  <= C_NOP;
        end
        RCD: if (r_t == C_RCD_LAST) begin
          r_state <= r_is_write ? WR : RD;
          r_pins  <= r_is_write ? C_WR : C_RD;
          r_a     <= {3'b000, r_col};
          r_t     <= '0;
        end
        RD, WR: if (r_t == C_CMD_LAST) begin
          r_state <= BURST;
          r_pins  <= C_NOP;
        end
        BURST: begin
          if (r_is_write && r_t == C_TS_OFF) begin
            r_state <= WREC;
          end else if (!r_is_write && r_t == C_RI_OFF) begin
            r_state <= PRE;
            r_pins  <= C_PRE;
            r_a     <= 13'h0400;
            r_t     <= '0;
          end
        end
        WREC: if (r_t == C_WREC_END) begin
          r_state <= PRE;
          r_pins  <= C_PRE;
          r_a     <= 13'h0400;
          r_t     <= '0;
        end
        PRE: if (r_t == C_CMD_LAST) begin
          r_state <= RP;
          r_pins  <= C_NOP;
        end
        RP: if (r_t == C_RP_LAST) begin
          // Banks are already closed here, so a pending refresh goes straight to REF.
          if (r_ref_pending) begin
            r_state <= REF;
            r_pins  <= C_REF;
            r_a     <= '0;
            r_t     <= '0;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        REF: if (r_t == C_CMD_LAST) begin
          r_state <= RFC;
          r_pins  <= C_NOP;
        end
        RFC: if (r_t == C_RFC_LAST) begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_pins  <= C_NOP;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // FIFO strobes are masked during reset so nothing is popped or captured that cycle.
  assign cmd_get   = r_cmd_get   & ~reset;
  assign wdata_get = r_wdata_get & ~reset;
  assign ret_put   = r_ret_put   & ~reset;
  assign {csbar, rasbar, casbar, webar} = r_pins;
  assign ba       = r_ba;
  assign a        = r_a;
  assign ts       = r_ts;
  assign ri       = r_ri;
  assign busy     = r_busy;
  assign ret_addr = r_ret_addr;

endmodule
`default_nettype wire

// File: tb/tb_ddr2_cmd_scheduler.sv
`default_nettype none
// Directed testbench for ddr2_cmd_scheduler; expected cycle tables are relative to ACT start.
module tb_ddr2_cmd_scheduler;

  localparam logic [3:0] P_NOP = 4'b0111;
  localparam logic [3:0] P_ACT = 4'b0011;
  localparam logic [3:0] P_RD  = 4'b0101;
  localparam logic [3:0] P_WR  = 4'b0100;
  localparam logic [3:0] P_PRE = 4'b0010;
  localparam logic [3:0] P_REF = 4'b0001;

  logic        clk = 1'b0;
  logic        reset, ready, cmd_empty;
  logic [27:0] cmd_data;
  logic        cmd_get, wdata_get, ret_put;
  logic [6:0]  in_fillcount, ret_fillcount;
  logic [24:0] ret_addr;
  logic        csbar, rasbar, casbar, webar;
  logic [1:0]  ba;
  logic [12:0] a;
  logic        ts, ri, busy;
  logic [3:0]  pins;

  int tests = 0;
  int fails = 0;

  assign pins = {csbar, rasbar, casbar, webar};

  always #5 clk = ~clk;

  ddr2_cmd_scheduler dut (
    .clk(clk), .reset(reset), .ready(ready), .cmd_empty(cmd_empty), .cmd_data(cmd_data),
    .cmd_get(cmd_get), .in_fillcount(in_fillcount), .wdata_get(wdata_get),
    .ret_fillcount(ret_fillcount), .ret_put(ret_put), .ret_addr(ret_addr),
    .csbar(csbar), .rasbar(rasbar), .casbar(casbar), .webar(webar),
    .ba(ba), .a(a), .ts(ts), .ri(ri), .busy(busy)
  );

  task automatic test_reset();
    reset = 1'b1; ready = 1'b0; cmd_empty = 1'b0; cmd_data = {3'b001, 25'h0000001};
    repeat (3) @(negedge clk);
    tests++;
    if ({pins, busy, cmd_get, wdata_get, ret_put, ts, ri} !== {P_NOP, 6'b0}) begin
      fails++;
      $display("FAIL reset_outputs got=%b exp=%b", {pins, busy, cmd_get, wdata_get, ret_put, ts, ri}, {P_NOP, 6'b0});
    end
    tests++;
    if ({a, ba, ret_addr} !== 40'h0) begin
      fails++; $display("FAIL reset_addr got=%h exp=0", {a, ba, ret_addr});
    end
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tests++;
      if (cmd_get !== 1'b0 || pins !== P_NOP || busy !== 1'b0) begin
        fails++; $display("FAIL not_ready_idle k=%0d cmd_get=%b pins=%b busy=%b exp 0/0111/0", k, cmd_get, pins, busy);
      end
    end
    cmd_empty = 1'b1; ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read();
    bit found = 0;
    cmd_data = {3'b001, 25'h0123456}; ret_fillcount = 7'd0; cmd_empty = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (pins === P_ACT) found = 1;
    end
    tests++;
    if (!found) begin
      fails++; $display("FAIL read_act_timeout got=no ACT exp=ACT"); cmd_empty = 1'b1; return;
    end
    tests++;
    if (cmd_get !== 1'b1 || ba !== 2'd1 || a !== 13'h0123) begin
      // row = addr[24:12] = 0x123, bank = addr[11:10] = 1
      fails++; $display("FAIL read_act got cmd_get=%b ba=%0d a=%h exp 1/1/0123", cmd_get, ba, a);
    end
    cmd_empty = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      logic [3:0] ep;
      logic       er;
      @(negedge clk);
      ep = P_NOP;
      if (k == 1) ep = P_ACT;
      if (k == 6 || k == 7) ep = P_RD;
      if (k == 22 || k == 23) ep = P_PRE;
      er = (k >= 14 && k <= 21);
      tests++;
      if (pins !== ep) begin fails++; $display("FAIL read_pins k=%0d got=%b exp=%b", k, pins, ep); end
      tests++;
      if (ret_put !== er || ri !== er) begin
        fails++; $display("FAIL read_beats k=%0d ret_put=%b ri=%b exp=%b", k, ret_put, ri, er);
      end
      if (k == 1) begin
        tests++; if (cmd_get !== 1'b0) begin fails++; $display("FAIL read_single_pop got=%b exp=0", cmd_get); end
      end
      if (k == 6) begin
        tests++; if (a !== 13'h0056) begin fails++; $display("FAIL read_col got=%h exp=0056", a); end
      end
      if (k == 14 || k == 21) begin
        tests++; if (ret_addr !== 25'h0123456) begin fails++; $display("FAIL read_ret_addr got=%h exp=0123456", ret_addr); end
      end
      if (k == 22) begin
        tests++; if (a[10] !== 1'b1) begin fails++; $display("FAIL read_pre_a10 got=%b exp=1", a[10]); end
      end
      if (k == 27 || k == 28) begin
        tests++; if (busy !== (k == 27)) begin fails++; $display("FAIL read_busy k=%0d got=%b exp=%b", k, busy, (k == 27)); end
      end
    end
  endtask

  task automatic test_write();
    bit found = 0;
    cmd_data = {3'b010, 25'h1002C07}; in_fillcount = 7'd8; cmd_empty = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (pins === P_ACT) found = 1;
    end
    tests++;
    if (!found) begin
      fails++; $display("FAIL write_act_timeout got=no ACT exp=ACT"); cmd_empty = 1'b1; return;
    end
    tests++;
    if (ba !== 2'd3 || a !== 13'h1002) begin
      fails++; $display("FAIL write_act got ba=%0d a=%h exp 3/1002", ba, a);
    end
    cmd_empty = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      logic [3:0] ep;
      logic       ew, et;
      @(negedge clk);
      ep = P_NOP;
      if (k == 1) ep = P_ACT;
      if (k == 6 || k == 7) ep = P_WR;
      if (k == 27 || k == 28) ep = P_PRE;
      ew = (k >= 11 && k <= 18);
      et = (k >= 12 && k <= 19);
      tests++;
      if (pins !== ep) begin fails++; $display("FAIL write_pins k=%0d got=%b exp=%b", k, pins, ep); end
      tests++;
      if (wdata_get !== ew || ts !== et) begin
        fails++; $display("FAIL write_data k=%0d wdata_get=%b ts=%b exp=%b/%b", k, wdata_get, ts, ew, et);
      end
      if (k == 6) begin
        tests++; if (a !== 13'h0007 || ba !== 2'd3) begin fails++; $display("FAIL write_col got a=%h ba=%0d exp 0007/3", a, ba); end
      end
      if (k == 32 || k == 33) begin
        tests++; if (busy !== (k == 32)) begin fails++; $display("FAIL write_busy k=%0d got=%b exp=%b", k, busy, (k == 32)); end
      end
    end
  endtask

  task automatic test_stall();
    bit done = 0;
    cmd_data = {3'b010, 25'h0000000}; in_fillcount = 7'd7; cmd_empty = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      tests++;
      if (cmd_get !== 1'b0 || pins !== P_NOP || busy !== 1'b0) begin
        fails++; $display("FAIL stall_write k=%0d cmd_get=%b pins=%b busy=%b exp 0/0111/0", k, cmd_get, pins, busy);
      end
    end
    in_fillcount = 7'd8;
    @(negedge clk);
    tests++;
    if (cmd_get !== 1'b1 || pins !== P_ACT) begin
      fails++; $display("FAIL stall_release_write got cmd_get=%b pins=%b exp 1/0011", cmd_get, pins);
    end
    cmd_empty = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (busy === 1'b0) done = 1;
    end
    tests++; if (!done) begin fails++; $display("FAIL stall_write_drain got busy=1 exp=0"); end
    // Return FIFO boundary: 57 entries blocks a read, 56 admits it.
    done = 0;
    cmd_data = {3'b001, 25'h0000000}; ret_fillcount = 7'd57; cmd_empty = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tests++;
      if (cmd_get !== 1'b0 || pins !== P_NOP) begin
        fails++; $display("FAIL stall_read k=%0d cmd_get=%b pins=%b exp 0/0111", k, cmd_get, pins);
      end
    end
    ret_fillcount = 7'd56;
    @(negedge clk);
    tests++;
    if (cmd_get !== 1'b1 || pins !== P_ACT) begin
      fails++; $display("FAIL stall_release_read got cmd_get=%b pins=%b exp 1/0011", cmd_get, pins);
    end
    cmd_empty = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (busy === 1'b0) done = 1;
    end
    tests++; if (!done) begin fails++; $display("FAIL stall_read_drain got busy=1 exp=0"); end
    ret_fillcount = 7'd0;
  endtask

  task automatic test_discard();
    int pulses = 0;
    cmd_data = {3'b111, 25'h1FFFFFF}; cmd_empty = 1'b0;
    @(negedge clk);
    tests++;
    if (cmd_get !== 1'b1) begin fails++; $display("FAIL discard_pop got=%b exp=1", cmd_get); end
    pulses = (cmd_get === 1'b1) ? 1 : 0;
    cmd_empty = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (cmd_get === 1'b1) pulses++;
      tests++;
      if (pins !== P_NOP || busy !== 1'b0) begin
        fails++; $display("FAIL discard_idle k=%0d pins=%b busy=%b exp 0111/0", k, pins, busy);
      end
    end
    tests++;
    if (pulses != 1) begin fails++; $display("FAIL discard_pulses got=%0d exp=1", pulses); end
  endtask

  task automatic test_refresh();
    bit done = 0;
    reset = 1'b1; ready = 1'b0; cmd_empty = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0; ready = 1'b1;
    // Expiry lands on the 3900th edge with ready high; ACT at 3883 puts it mid-burst.
    repeat (3882) @(negedge clk);
    cmd_data = {3'b001, 25'h0123456}; ret_fillcount = 7'd0; cmd_empty = 1'b0;
    @(negedge clk);
    tests++;
    if (pins !== P_ACT) begin
      fails++; $display("FAIL refresh_act_start got=%b exp=%b", pins, P_ACT); cmd_empty = 1'b1; return;
    end
    cmd_data = {3'b001, 25'h0000400};
    for (int k = 1; k <= 93; k++) begin
      logic [3:0] ep;
      logic       er;
      @(negedge clk);
      ep = P_NOP;
      if (k == 1 || k == 93) ep = P_ACT;
      if (k == 6 || k == 7) ep = P_RD;
      if (k == 22 || k == 23) ep = P_PRE;
      if (k == 28 || k == 29) ep = P_REF;
      er = (k >= 14 && k <= 21);
      tests++;
      if (pins !== ep) begin fails++; $display("FAIL refresh_pins k=%0d got=%b exp=%b", k, pins, ep); end
      tests++;
      if (ret_put !== er) begin fails++; $display("FAIL refresh_burst k=%0d ret_put=%b exp=%b", k, ret_put, er); end
      if (k == 92) begin
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL refresh_idle got busy=%b exp=0", busy); end
      end
      if (k == 93) begin
        tests++; if (cmd_get !== 1'b1) begin fails++; $display("FAIL refresh_next_pop got=%b exp=1", cmd_get); end
      end
    end
    cmd_empty = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (busy === 1'b0) done = 1;
    end
    tests++; if (!done) begin fails++; $display("FAIL refresh_drain got busy=1 exp=0"); end
  endtask

  task automatic test_reset_mid_write();
    bit found = 0;
    cmd_data = {3'b010, 25'h0001000}; in_fillcount = 7'd8; cmd_empty = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (pins === P_ACT) found = 1;
    end
    cmd_empty = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (pins === P_WR) found = 1;
    end
    tests++;
    if (!found) begin fails++; $display("FAIL rst_mid_wr_timeout got=no WR exp=WR"); return; end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if ({pins, ts, wdata_get, busy, cmd_get} !== {P_NOP, 4'b0}) begin
      fails++; $display("FAIL rst_mid_wr got=%b exp=%b", {pins, ts, wdata_get, busy, cmd_get}, {P_NOP, 4'b0});
    end
    tests++;
    if ({a, ba} !== 15'h0) begin fails++; $display("FAIL rst_mid_wr_addr got=%h exp=0", {a, ba}); end
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      tests++;
      if (pins !== P_NOP || ts !== 1'b0 || wdata_get !== 1'b0) begin
        fails++; $display("FAIL rst_mid_wr_after k=%0d pins=%b ts=%b wdata_get=%b exp 0111/0/0", k, pins, ts, wdata_get);
      end
    end
  endtask

  initial begin
    reset = 1'b1; ready = 1'b0; cmd_empty = 1'b1; cmd_data = '0;
    in_fillcount = '0; ret_fillcount = '0;
    test_reset();
    test_read();
    test_write();
    test_stall();
    test_discard();
    test_refresh();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
